// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: source/state encodings
// and the queued long-latency result entry.
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_DATA_W  = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;

    typedef enum logic {
        NORMAL,
        STALL
    } wb_arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO for long-latency results. The head is visible
// combinationally so a pop decision can write it in the same cycle.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // The extra MSB on each pointer separates full (MSBs differ) from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign head  = mem_q[rptr_q[PTR_W-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// queued long-latency results, with a starvation stall and a busy scoreboard.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wb_valid,
    input  logic [4:0]            pipe_wb_rd,
    input  logic [DATA_W-1:0]     pipe_wb_data,
    input  logic                  mc_valid,
    input  logic [4:0]            mc_rd,
    input  logic [DATA_W-1:0]     mc_data,
    output logic                  mc_ready,
    input  logic                  mc_issue_valid,
    input  logic [4:0]            mc_issue_rd,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [31:0]           busy,
    output logic                  protocol_err
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } entry_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT);

    wb_arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  stall_q, stall_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [31:0]           busy_q, busy_d;
    logic                  err_q, err_d;

    wb_src_e               src;
    entry_t                mc_entry;
    entry_t                fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  mc_xfer;
    logic                  mc_keep;
    logic                  pipe_wr;
    logic                  issue_set;
    logic                  clr_en;
    logic [REG_ADDR_W-1:0] clr_rd;

    assign mc_entry  = '{rd: mc_rd, data: mc_data};
    assign mc_ready  = !fifo_full;
    assign mc_xfer   = mc_valid && !fifo_full;
    // Results for x0 are accepted but never written or queued.
    assign mc_keep   = mc_xfer && (mc_rd != '0);
    assign pipe_wr   = pipe_wb_valid && (pipe_wb_rd != '0);
    assign issue_set = mc_issue_valid && (mc_issue_rd != '0);

    wb_arb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mc_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        src     = SRC_NONE;

        if (pipe_wr) begin
            src = SRC_PIPE;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (mc_keep) begin
            src = SRC_BYPASS;
        end

        case (state_q)
            NORMAL: begin
                if (fifo_empty || (src == SRC_FIFO)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STARVE_LIMIT - 2)) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                cnt_d = '0;
                // A pipeline that ignores the stall still owns the slot.
                if (pipe_wb_valid) begin
                    src   = pipe_wr ? SRC_PIPE : SRC_NONE;
                    err_d = 1'b1;
                end else begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase

        fifo_pop  = (src == SRC_FIFO);
        fifo_push = mc_keep && (src != SRC_BYPASS);

        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        clr_en  = 1'b0;
        clr_rd  = '0;
        case (src)
            SRC_PIPE: begin
                we_d    = 1'b1;
                waddr_d = pipe_wb_rd;
                wdata_d = pipe_wb_data;
            end
            SRC_FIFO: begin
                we_d    = 1'b1;
                waddr_d = fifo_head.rd;
                wdata_d = fifo_head.data;
                clr_en  = 1'b1;
                clr_rd  = fifo_head.rd;
            end
            SRC_BYPASS: begin
                we_d    = 1'b1;
                waddr_d = mc_rd;
                wdata_d = mc_data;
                clr_en  = 1'b1;
                clr_rd  = mc_rd;
            end
            default: ;
        endcase

        if (issue_set && busy_q[mc_issue_rd]) begin
            err_d = 1'b1;
        end
        if (pipe_wr && busy_q[pipe_wb_rd]) begin
            err_d = 1'b1;
        end
        if (mc_keep && !busy_q[mc_rd]) begin
            err_d = 1'b1;
        end

        // Set is applied after clear so a same-cycle re-issue keeps the bit.
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (issue_set) begin
            busy_d[mc_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        stall_d = (state_d == STALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign pipe_stall   = stall_q;
    assign rf_we        = we_q;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign busy         = busy_q;
    assign protocol_err = err_q;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline's MEM/WB writeback (`rd`, data) and result returns from a long-latency execution unit (divider/multiplier). Long-latency results queue in a small FIFO and drain into idle writeback slots. A starvation counter briefly stalls the pipeline if the queue is not draining. A per-register busy scoreboard lets issue logic detect hazards on pending destinations.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `FIFO_DEPTH`, 2, long-latency result queue entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, consecutive non-draining cycles before a forced stall (≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `pipe_wb_valid`  in  1  pipeline writeback valid this cycle
- `pipe_wb_rd`  in  5  pipeline destination register
- `pipe_wb_data`  in  DATA_W  pipeline writeback data
- `mc_valid`  in  1  long-latency result valid
- `mc_rd`  in  5  long-latency destination register
- `mc_data`  in  DATA_W  long-latency result data
- `mc_ready`  out  1  arbiter accepts long-latency result
- `mc_issue_valid`  in  1  long-latency instruction issued this cycle
- `mc_issue_rd`  in  5  its destination register
- `pipe_stall`  out  1  pipeline must present no writeback next cycle
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  register-file write address
- `rf_wdata`  out  DATA_W  register-file write data
- `busy`  out  32  pending long-latency destination bitmap
- `protocol_err`  out  1  sticky protocol violation flag

## Operation
Decided: one clock; reset is synchronous and active-high.

- `mc_ready = !fifo_full`; a result transfers when `mc_valid && mc_ready`.
- Writes to x0 are never issued. A pipeline write with rd 0 leaves the slot free. A long-latency result with rd 0 is accepted and discarded.
- Slot selection, in priority order:
  1. `pipe_wb_valid && pipe_wb_rd!=0` → the pipeline writes.
  2. Otherwise, if the FIFO is non-empty → pop the head and write it.
  3. Otherwise, if a long-latency result transfers this cycle → bypass and write it directly (it is not enqueued).
- If the slot is taken by the pipeline or the FIFO head, a transferring result is enqueued. Push and pop in the same cycle are legal.
- FSM states:
  - NORMAL: starvation counter `starve_cnt` increments each cycle the FIFO is non-empty and does not pop. It clears on pop or when the FIFO is empty. When it reaches `STARVE_LIMIT-1` while incrementing → STALL.
  - STALL: `pipe_stall=1`, and the FIFO head is popped unconditionally. If `pipe_wb_valid` is also asserted, the pipeline still wins, the pop is skipped, `protocol_err` is set, and the FSM stays in STALL. Otherwise → NORMAL, and `starve_cnt` clears.
- Scoreboard:
  - `busy[r]` sets on `mc_issue_valid` (r≠0).
  - It clears when a long-latency result for r is written (popped or bypassed) or discarded.
  - If set and clear hit the same register in the same cycle, set wins.
  - `busy[0]` is always 0.
- `protocol_err` (sticky until reset) is set on any of:
  - issue to an already-busy rd;
  - a pipeline write to a busy rd (WAW);
  - a long-latency result whose rd is not busy;
  - a pipeline write during STALL.

## Timing
- `rf_we`, `rf_waddr`, `rf_wdata`, `pipe_stall`, `busy`, and `protocol_err` are registered.
- Writeback latency:
  - Pipeline and bypass paths: 1 cycle from input to `rf_we`.
  - Queued entries: 1 cycle after the pop decision.
- `mc_ready` is combinational from FIFO occupancy only. It never depends on `mc_valid`.
- `busy` reflects the issue one cycle after `mc_issue_valid`.
- Reset values: all outputs 0, except `mc_ready`, which is 1 (FIFO empty). Reset also sets the FSM to NORMAL, the counter to 0, and the FIFO to empty.
- Reset asserted mid-operation discards all queued results and busy bits in the same cycle.
- FIFO pointers wrap modulo `FIFO_DEPTH`. An extra pointer bit distinguishes full from empty.

## Structure
- `wb_arb_pkg` contains:
  - `REG_ADDR_W=5`;
  - `wb_src_e` (SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_BYPASS);
  - `wb_arb_state_e` (NORMAL, STALL);
  - the `wb_entry_t` struct (rd, data).
- Sub-module `wb_arb_fifo` is a synchronous FIFO of `wb_entry_t` with push, pop, full, and empty. The scoreboard and FSM live in the top module.

## Test plan
- Bypass: pipeline idle, FIFO empty, `mc_valid` with rd 5, data 0xDEAD_BEEF → next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEAD_BEEF`, and `busy[5]` clears.
- Contention: pipeline writes rd 3 continuously while the long-latency unit returns rd 7 → rd 7 is queued. When the pipeline drops valid, rd 7 is written the next cycle.
- Full queue: two queued results with the pipeline saturated → `mc_ready=0`. A third result is held until a pop. No result is lost.
- Starvation: FIFO non-empty with the pipeline saturated (`STARVE_LIMIT=8`) → `pipe_stall=1` on cycle 8. The head is written in the stall cycle, then the FSM returns to NORMAL.
- x0 and protocol checks:
  - A long-latency result with rd 0 → no `rf_we`.
  - A second issue to a busy rd 9 → `protocol_err=1`, which holds until `rst`.
- Reset mid-drain: `rst` asserted with 2 entries queued → the next cycle has `rf_we=0`, `busy=0`, `mc_ready=1`, and `pipe_stall=0`.
